// File: rtl/anim_pkg.sv
// Shared definitions for the animation sequencer: play modes, ping-pong
// direction and the per-animation last-frame table.
package anim_pkg;

  typedef enum logic [1:0] {
    MODE_LOOP     = 2'b00,
    MODE_PINGPONG = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_AUTO     = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  localparam int ANIM_TBL_N = 34;

  // Last frame index of each animation; -1 marks an index with no entry.
  function automatic int anim_limit(input int idx);
    int lim;
    case (idx) inside
      0:        lim = 9;
      1:        lim = 11;
      [2:6]:    lim = 5;
      7:        lim = 1;
      [8:9]:    lim = 3;
      [10:14]:  lim = 1;
      15:       lim = 3;
      16:       lim = 4;
      17:       lim = 1;
      [18:22]:  lim = 6;
      23:       lim = 3;
      [24:27]:  lim = 15;
      28:       lim = 31;
      29:       lim = 3;
      30:       lim = 10;
      31:       lim = 31;
      32:       lim = 4;
      33:       lim = 8;
      default:  lim = -1;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/anim_limit_rom.sv
// Combinational lookup of the last frame index for an animation; undefined
// indices play the full frame range.
module anim_limit_rom
  import anim_pkg::*;
#(
  parameter int ANI_W   = 6,
  parameter int FRAME_W = 6,
  parameter int N_ANI   = 34
) (
  input  logic [ANI_W-1:0]   idx,
  output logic [FRAME_W-1:0] limit
);

  int lim;

  always_comb begin
    lim   = anim_limit(int'(idx));
    limit = '1;
    if (int'(idx) < N_ANI && lim >= 0)
      limit = FRAME_W'(lim);
  end

endmodule

// File: rtl/anim_sequencer.sv
// Frame sequencer: a prescaler paces frame steps; the step rule depends on
// the play mode (loop, ping-pong, one-shot, auto-advance through animations).
module anim_sequencer
  import anim_pkg::*;
#(
  parameter int ANI_W   = 6,
  parameter int FRAME_W = 6,
  parameter int PRESC_W = 24,
  parameter int N_ANI   = 34
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [ANI_W-1:0]   animation,
  input  logic [1:0]         mode,
  input  logic [PRESC_W-1:0] presc,
  input  logic               pause,
  input  logic               restart,
  output logic [FRAME_W-1:0] frame,
  output logic [ANI_W-1:0]   ani_cur,
  output logic               frame_strobe,
  output logic               done
);

  logic [FRAME_W-1:0] frame_q, nxt_frame;
  logic [ANI_W-1:0]   ani_q, nxt_ani;
  logic [PRESC_W-1:0] cnt_q, nxt_cnt;
  dir_e               dir_q, nxt_dir;
  logic               done_q, nxt_done;
  logic               strobe_q, nxt_strobe;
  logic [FRAME_W-1:0] limit;
  logic               tick;
  mode_e              md;

  anim_limit_rom #(.ANI_W(ANI_W), .FRAME_W(FRAME_W), .N_ANI(N_ANI)) u_rom (
    .idx   (ani_q),
    .limit (limit)
  );

  assign md   = mode_e'(mode);
  // >= rather than == so a presc lowered below the running count still ticks.
  assign tick = (cnt_q >= presc);

  always_comb begin
    nxt_frame  = frame_q;
    nxt_ani    = ani_q;
    nxt_cnt    = cnt_q;
    nxt_dir    = dir_q;
    nxt_done   = done_q;
    nxt_strobe = 1'b0;
    if (restart || (md != MODE_AUTO && animation != ani_q)) begin
      nxt_ani   = animation;
      nxt_frame = '0;
      nxt_cnt   = '0;
      nxt_dir   = DIR_UP;
      nxt_done  = 1'b0;
    end else if (!pause) begin
      if (!tick) begin
        nxt_cnt = cnt_q + 1'b1;
      end else begin
        nxt_cnt = '0;
        if (frame_q > limit) begin
          nxt_frame = '0;
          nxt_dir   = DIR_UP;
        end else begin
          case (md)
            MODE_LOOP:
              nxt_frame = (frame_q == limit) ? '0 : frame_q + 1'b1;
            MODE_AUTO:
              if (frame_q == limit) begin
                nxt_frame = '0;
                nxt_ani   = (ani_q >= ANI_W'(N_ANI - 1)) ? '0 : ani_q + 1'b1;
              end else begin
                nxt_frame = frame_q + 1'b1;
              end
            MODE_PINGPONG:
              if (limit == '0) begin
                nxt_frame = '0;
              end else if (dir_q == DIR_UP) begin
                if (frame_q == limit) begin
                  nxt_dir   = DIR_DN;
                  nxt_frame = limit - 1'b1;
                end else begin
                  nxt_frame = frame_q + 1'b1;
                end
              end else begin
                if (frame_q == '0) begin
                  nxt_dir   = DIR_UP;
                  nxt_frame = FRAME_W'(1);
                end else begin
                  nxt_frame = frame_q - 1'b1;
                end
              end
            default: begin
              // One-shot: done rises together with the final frame.
              if (frame_q < limit) begin
                nxt_frame = frame_q + 1'b1;
                nxt_done  = (frame_q + 1'b1 == limit);
              end else begin
                nxt_done  = 1'b1;
              end
            end
          endcase
        end
        if (md != MODE_PINGPONG) nxt_dir  = DIR_UP;
        if (md != MODE_ONESHOT)  nxt_done = 1'b0;
        nxt_strobe = (nxt_frame != frame_q) || (nxt_ani != ani_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q  <= '0;
      ani_q    <= '0;
      cnt_q    <= '0;
      dir_q    <= DIR_UP;
      done_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else if (ena) begin
      frame_q  <= nxt_frame;
      ani_q    <= nxt_ani;
      cnt_q    <= nxt_cnt;
      dir_q    <= nxt_dir;
      done_q   <= nxt_done;
      strobe_q <= nxt_strobe;
    end else begin
      strobe_q <= 1'b0;
    end
  end

  assign frame        = frame_q;
  assign ani_cur      = ani_q;
  assign frame_strobe = strobe_q;
  assign done         = done_q;

endmodule

// File: doc/anim_sequencer.md
ANIM_SEQUENCER -- requirements
Module: anim_sequencer

Interface
REQ-001 SHALL have parameter ANI_W, default 6, animation index width.
REQ-002 SHALL have parameter FRAME_W, default 6, frame index width.
REQ-003 SHALL have parameter PRESC_W, default 24, prescaler width.
REQ-004 SHALL have parameter N_ANI, default 34, number of defined animations (indices 0..N_ANI-1).
REQ-005 SHALL have port clk  input  1  system clock; one clock domain, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ena  input  1  global enable; low freezes all state except reset.
REQ-008 SHALL have port animation  input  ANI_W  requested animation index.
REQ-009 SHALL have port mode  input  2  00 LOOP, 01 PINGPONG, 10 ONESHOT, 11 AUTO.
REQ-010 SHALL have port presc  input  PRESC_W  clock cycles per frame minus 1.
REQ-011 SHALL have port pause  input  1  hold prescaler and frame.
REQ-012 SHALL have port restart  input  1  synchronous restart of current sequence.
REQ-013 SHALL have port frame  output  FRAME_W  current frame index.
REQ-014 SHALL have port ani_cur  output  ANI_W  animation currently played.
REQ-015 SHALL have port frame_strobe  output  1  one-cycle pulse when a new frame value appears.
REQ-016 SHALL have port done  output  1  ONESHOT finished, frame held at limit.

Function
REQ-017 Limit per animation SHALL come from a constant table: 0->9, 1->11, 2..6->5, 7->1, 8,9->3, 10..14->1, 15->3, 16->4, 17->1, 18..22->6, 23->3, 24..27->15, 28->31, 29->3, 30->10, 31->31, 32->4, 33->8; any index >= N_ANI -> 2^FRAME_W-1.
REQ-018 Prescaler counter SHALL count 0..presc while ena=1 and pause=0; tick asserted in the cycle counter==presc, counter returns to 0 on that edge; frame period = presc+1 cycles; presc=0 gives a tick every cycle.
REQ-019 On tick, frame SHALL update on the same edge; new value and frame_strobe=1 visible the following cycle.
REQ-020 LOOP: frame==limit -> 0, else frame+1.
REQ-021 PINGPONG: internal dir up/down; up at limit -> dir down, frame limit-1; down at 0 -> dir up, frame 1; limit==0 -> frame stays 0, no strobe.
REQ-022 ONESHOT: frame<limit -> frame+1; frame==limit -> hold, done=1, no further strobes.
REQ-023 AUTO: as LOOP, but at wrap ani_cur increments (N_ANI-1 -> 0) and frame -> 0; animation input ignored except at restart.
REQ-024 In LOOP/PINGPONG/ONESHOT, animation != ani_cur SHALL on the next edge load ani_cur=animation, frame=0, prescaler=0, dir up, done=0, no strobe.
REQ-025 restart=1 SHALL load ani_cur=animation, frame=0, prescaler=0, dir up, done=0; restart has priority over tick and animation change.
REQ-026 Mode change SHALL take effect at next tick; dir forced up when mode!=PINGPONG; done cleared when mode!=ONESHOT.
REQ-027 If frame > limit (after limit table change cannot occur; defensive), next tick SHALL set frame=0.
REQ-028 ena=0 SHALL freeze all registers and force frame_strobe=0; pause=1 freezes prescaler and frame only.

Reset
REQ-029 rst_n low SHALL asynchronously set frame=0, ani_cur=0, prescaler=0, dir up, frame_strobe=0, done=0.
REQ-030 Release SHALL be sampled synchronously; first tick occurs presc+1 cycles after release with ena=1.

Structure
REQ-031 Shared package anim_pkg SHALL hold mode encodings and the limit table constants.
REQ-032 Combinational sub-module anim_limit_rom (index -> limit) SHALL be instantiated once; remainder in anim_sequencer.

Verification
REQ-033 LOOP, animation=0, presc=3: frame 0..9 then 0, strobe every 4 cycles, period 40 cycles.
REQ-034 PINGPONG, animation=7 (limit 1), presc=0: frame 0,1,0,1...; animation=16: 0,1,2,3,4,3,2,1,0,1.
REQ-035 ONESHOT, animation=33, presc=1: frame reaches 8 after 16 cycles, done=1, frame holds, no strobes; restart -> frame 0, done 0.
REQ-036 AUTO, presc=0, starting ani_cur=32: after 5 ticks ani_cur=33 frame 0; after 9 more ani_cur=0.
REQ-037 Mid-frame animation change 0->28 with presc=10 at count 5: next cycle frame 0, ani_cur 28, prescaler 0; pause=1 for 20 cycles holds frame; rst_n low mid-run -> all outputs 0 immediately.
